// File: rtl/scan_mux_pkg.sv
// Shared encodings and parameter limits for the scan/fixed channel multiplexer.
`timescale 1ns/1ps
package scan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_SCAN  = 1'b1
    } mode_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 64;
    localparam int W_MIN = 1;
    localparam int W_MAX = 64;

    // Next round-robin start position after a grant, wrapping past the last channel.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/scan_mux_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr, wrapping N-1 -> 0.
// Purely combinational; the caller owns the pointer register.
`timescale 1ns/1ps
module rr_arbiter
    import scan_mux_pkg::*;
#(
    parameter  int N  = 16,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    // One extra bit so ptr + offset cannot overflow before the modulo-N fold.
    logic [SW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (SW+1)'(i);
            if (pos >= (SW+1)'(N)) begin
                pos = pos - (SW+1)'(N);
            end
            if (!any && req[pos[SW-1:0]]) begin
                any                 = 1'b1;
                idx                 = pos[SW-1:0];
                grant[pos[SW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N-channel to one registered output, fixed-select or round-robin scan.
// One cycle from capture to out_valid; holds the word while out_ready is low.
`timescale 1ns/1ps
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ack,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic          free;
    logic          sel_ok;
    logic          fixed_hit;
    logic          cap;
    logic [SW-1:0] cap_ch;
    logic [W-1:0]  cap_data;
    logic [SW-1:0] ptr;
    logic [N-1:0]  arb_grant;
    logic [SW-1:0] arb_idx;
    logic          arb_any;

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign free      = !out_valid || out_ready;
    // sel can address past N-1 when N is not a power of two; such indices never hit.
    assign sel_ok    = ({1'b0, sel} < (SW+1)'(N));
    assign fixed_hit = sel_ok && in_valid[sel];

    always_comb begin
        cap    = 1'b0;
        cap_ch = sel;
        if (mode_e'(mode) == MODE_SCAN) begin
            cap    = free && arb_any;
            cap_ch = arb_idx;
        end else begin
            cap    = free && fixed_hit;
            cap_ch = sel;
        end
    end

    assign cap_data = in_data[cap_ch*W +: W];
    // Gated by rst_n so no ack escapes while the output register is held in reset.
    assign in_ack   = (rst_n && cap) ? (N'(1) << cap_ch) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (free) begin
                out_valid <= cap;
            end
            if (cap) begin
                out_data <= cap_data;
                out_ch   <= cap_ch;
            end
            if (cap && mode_e'(mode) == MODE_SCAN) begin
                ptr <= SW'(wrap_inc(int'(arb_idx), N));
            end
        end
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N, default 16, number of input channels (2..64).
REQ-002 Parameter W, default 1, data width per channel (1..64).
REQ-003 Parameter SW, default $clog2(N), width of channel index; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  N*W  channel c occupies bits [c*W +: W].
REQ-007 in_valid  input  N  per-channel data-valid.
REQ-008 in_ack  output  N  one-hot pulse, one cycle, on the cycle channel c's data is captured.
REQ-009 sel  input  SW  channel index used in FIXED mode.
REQ-010 mode  input  1  0 = FIXED, 1 = SCAN (round-robin over valid channels).
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_ch  output  SW  index of channel held in out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a captured word.
REQ-014 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.

Function
REQ-015 The output register is "free" when out_valid=0 or (out_valid=1 and out_ready=1) in the same cycle.
REQ-016 FIXED: when free, sel < N and in_valid[sel]=1, capture in_data[sel] and sel into out_data/out_ch, set out_valid and pulse in_ack[sel]; latency one cycle from input to out_valid.
REQ-017 FIXED: sel >= N (N not a power of two) shall capture nothing and never pulse in_ack.
REQ-018 SCAN: when free, grant the first valid channel at or after pointer ptr (wrapping N-1 -> 0); capture it as in REQ-016; then ptr <= granted+1, wrapping to 0 after N-1.
REQ-019 SCAN: no valid channel -> no capture, ptr unchanged.
REQ-020 When not free, in_valid/sel/mode changes shall not alter out_data, out_ch or out_valid; in_ack stays 0.
REQ-021 Free with no capture -> out_valid <= 0 next cycle.
REQ-022 Back-to-back: with out_ready held 1 and sources valid, one capture per cycle (full throughput).
REQ-023 mode change takes effect on the next capture decision; ptr is retained across FIXED periods.
REQ-024 At most one in_ack bit high per cycle.

Reset
REQ-025 rst_n low shall immediately force out_valid=0, out_data=0, out_ch=0, in_ack=0, ptr=0, independent of clk.
REQ-026 Reset asserted mid-transfer discards the held word; first capture after rst_n rises uses ptr=0.

Structure
REQ-027 Package scan_mux_pkg holds the mode encoding (FIXED=0, SCAN=1) and the N/W range limits.
REQ-028 Sub-module rr_arbiter (N-bit request, SW-bit pointer -> one-hot grant, grant index, any-grant) implements REQ-018/019.

Verification
REQ-029 N=16,W=8, FIXED, sel=5, in_valid[5]=1, data 0xA5, out_ready=1 -> next cycle out_data=0xA5, out_ch=5, out_valid=1; in_ack=16'h0020 for one cycle.
REQ-030 SCAN, in_valid=16'h8101, out_ready=1 -> captures in order ch 0, 8, 15, 0; in_ack pulses in that order on consecutive cycles.
REQ-031 Backpressure: out_valid=1, out_ready=0 for 4 cycles while sel and in_data change -> out_data/out_ch constant, in_ack=0; release -> new capture same cycle.
REQ-032 N=12, FIXED, sel=13, in_valid all 1 -> out_valid stays 0, in_ack stays 0.
REQ-033 SCAN at ptr=9, assert rst_n=0 between clock edges -> outputs zero before next edge; after release, in_valid=all-ones grants ch 0 first.
REQ-034 SCAN, in_valid=0 for 3 cycles then in_valid[3]=1 -> ptr unchanged while idle, ch 3 captured, out_valid drops after consumption with no requests.
